// File: rtl/dff_bist_ctrl.sv
`timescale 1ns/1ps
// dff_bist_ctrl: LFSR-driven self-test for single-bit delay elements.
// Drives d_out, checks q_in against a LATENCY-deep expected line, reports pass and error stats.
module dff_bist_ctrl #(
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             d_out,
  input  logic             q_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [15:0]      first_err_idx
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned IDX_W = 16;
  localparam logic [CNT_W-1:0] LAST_VEC   = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(LATENCY - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;
  localparam logic [IDX_W-1:0] IDX_NONE   = '1;

  // Elaboration-time guards on the legal parameter space
  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("dff_bist_ctrl: LATENCY must be 1..8");
  end
  if (NUM_VECTORS < 1 || NUM_VECTORS > 65535) begin : g_bad_num_vectors
    $error("dff_bist_ctrl: NUM_VECTORS must be 1..65535");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("dff_bist_ctrl: LFSR_SEED must be non-zero");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [15:0]        lfsr, lfsr_nxt;
  logic [LATENCY-1:0] exp_line, exp_line_nxt;
  logic [LATENCY-1:0] exp_vld, exp_vld_nxt;
  logic [IDX_W-1:0]   cmp_idx, cmp_idx_nxt;
  logic               d_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [ERR_W-1:0]   err_nxt;
  logic [IDX_W-1:0]   first_nxt;
  logic               run_start, cmp_vld, mismatch;

  // Fibonacci step for x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Next-state, stimulus, compare and result logic
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    lfsr_nxt     = lfsr;
    d_nxt        = 1'b0;
    run_start    = 1'b0;
    cmp_vld      = exp_vld[LATENCY-1];
    mismatch     = cmp_vld & (q_in ^ exp_line[LATENCY-1]);
    err_nxt      = err_count;
    first_nxt    = first_err_idx;
    cmp_idx_nxt  = cmp_idx;
    pass_nxt     = pass;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
          d_nxt     = LFSR_SEED[0];
          lfsr_nxt  = lfsr_adv(LFSR_SEED);
          run_start = 1'b1;
        end
      end
      S_RUN: begin
        if (cnt == LAST_VEC) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt  = cnt + 1'b1;
          d_nxt    = lfsr[0];
          lfsr_nxt = lfsr_adv(lfsr);
        end
      end
      S_DRAIN: begin
        if (cnt == LAST_DRAIN) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // The line is empty whenever IDLE is left, so a new run never sees stale compares
    if (run_start) begin
      err_nxt     = '0;
      first_nxt   = IDX_NONE;
      cmp_idx_nxt = '0;
      pass_nxt    = 1'b0;
    end else begin
      if (mismatch && (err_count != ERR_MAX)) err_nxt = err_count + 1'b1;
      if (mismatch && (first_err_idx == IDX_NONE)) first_nxt = cmp_idx;
      if (cmp_vld) cmp_idx_nxt = cmp_idx + 1'b1;
      if (state == S_DRAIN && state_nxt == S_DONE) pass_nxt = (err_nxt == '0);
    end

    exp_line_nxt = LATENCY'({exp_line, d_out});
    exp_vld_nxt  = LATENCY'({exp_vld, state == S_RUN});
    done_nxt     = (state_nxt == S_DONE);
    busy_nxt     = (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      lfsr          <= LFSR_SEED;
      exp_line      <= '0;
      exp_vld       <= '0;
      cmp_idx       <= '0;
      d_out         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= IDX_NONE;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      lfsr          <= lfsr_nxt;
      exp_line      <= exp_line_nxt;
      exp_vld       <= exp_vld_nxt;
      cmp_idx       <= cmp_idx_nxt;
      d_out         <= d_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      pass          <= pass_nxt;
      err_count     <= err_nxt;
      first_err_idx <= first_nxt;
    end
  end

endmodule

// File: tb/tb_dff_bist_ctrl.sv
`timescale 1ns/1ps
// tb_dff_bist_ctrl: scoreboard bench; stimulus pushes expected run results, a monitor
// checks them on each done pulse along with the d_out stream against a reference LFSR.
module tb_dff_bist_ctrl;

  localparam int unsigned NV    = 256;
  localparam int unsigned ERR_W = 8;
  localparam logic [15:0] SEED  = 16'hACE1;

  typedef struct {
    bit pass;
    int err;
    int first;
    int blen;
    bit gap;
    bit abort;
  } exp_t;

  logic             clk, reset, start_a, start_b, sel;
  logic             a_d, a_q, a_busy, a_done, a_pass;
  logic             b_d, b_q, b_busy, b_done, b_pass;
  logic [ERR_W-1:0] a_err, b_err;
  logic [15:0]      a_first, b_first;
  logic             a_ff1, a_ff2, b_ff1, b_ff2;
  int               mode;

  logic             m_d, m_busy, m_done, m_pass;
  logic [ERR_W-1:0] m_err;
  logic [15:0]      m_first;

  exp_t sb[$];
  exp_t me;
  bit   vref [0:NV-1];
  int   n_cmp, n_bad;
  bit   bprev;
  int   blen, sbad, sfirst, last_done, cyc, done_cnt;

  dff_bist_ctrl #(.LATENCY(1), .NUM_VECTORS(NV), .LFSR_SEED(SEED), .ERR_W(ERR_W)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .d_out(a_d), .q_in(a_q),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err), .first_err_idx(a_first));

  dff_bist_ctrl #(.LATENCY(2), .NUM_VECTORS(NV), .LFSR_SEED(SEED), .ERR_W(ERR_W)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .d_out(b_d), .q_in(b_q),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err), .first_err_idx(b_first));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Elements under test: one flop, or a two-flop chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_ff1 <= 1'b0; a_ff2 <= 1'b0; b_ff1 <= 1'b0; b_ff2 <= 1'b0;
    end else begin
      a_ff1 <= a_d; a_ff2 <= a_ff1; b_ff1 <= b_d; b_ff2 <= b_ff1;
    end
  end

  always_comb begin
    case (mode)
      0:       a_q = a_ff1;
      1:       a_q = ~a_ff1;
      2:       a_q = 1'b0;
      default: a_q = a_ff2;
    endcase
  end
  assign b_q = b_ff2;

  assign m_d     = sel ? b_d     : a_d;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_pass  = sel ? b_pass  : a_pass;
  assign m_err   = sel ? b_err   : a_err;
  assign m_first = sel ? b_first : a_first;

  task automatic check(input string nm, input longint got, input longint req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, got, req);
    end
  endtask

  task automatic flag(input string nm, input longint got);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0d, required none", nm, got);
  endtask

  function automatic exp_t mk(bit p, int e, int f, int bl, bit g, bit ab);
    exp_t r;
    r.pass = p; r.err = e; r.first = f; r.blen = bl; r.gap = g; r.abort = ab;
    return r;
  endfunction

  function automatic bit dv(input int j);
    if (j < 0 || j >= int'(NV)) return 1'b0;
    return vref[j];
  endfunction

  // Reference result for an element of the given depth seen through a controller of latency lat
  function automatic void model(input int kind, input int lat, input int depth,
                                output int err, output int first);
    bit q;
    err = 0;
    first = 'hFFFF;
    for (int i = 0; i < int'(NV); i++) begin
      q = (kind == 2) ? 1'b0 : (dv(i + lat - depth) ^ (kind == 1));
      if (q != vref[i]) begin
        if (err < 255) err++;
        if (first == 'hFFFF) first = i;
      end
    end
  endfunction

  task automatic chk_rst(input string tag);
    check({tag, "_d_out"}, m_d, 0);
    check({tag, "_busy"}, m_busy, 0);
    check({tag, "_done"}, m_done, 0);
    check({tag, "_pass"}, m_pass, 0);
    check({tag, "_err_count"}, m_err, 0);
    check({tag, "_first_err_idx"}, m_first, 'hFFFF);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_done && k < budget);
    if (!m_done) flag("done_timeout", k);
  endtask

  task automatic do_run(input bit s, input int md, input exp_t e);
    sel = s;
    mode = md;
    sb.push_back(e);
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    wait_done(2000);
    @(negedge clk);
  endtask

  // Monitor: per-run stream check, result check on done, IDLE gap check on back-to-back runs
  initial begin
    bprev = 1'b0; blen = 0; sbad = 0; sfirst = -1; last_done = -100; cyc = 0; done_cnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        bprev = 1'b0;
        blen = 0;
        if (sb.size() > 0 && sb[0].abort) me = sb.pop_front();
        continue;
      end
      if (m_busy && !bprev) begin
        blen = 0; sbad = 0; sfirst = -1;
        if (sb.size() == 0) flag("unexpected_run", cyc);
        else begin
          check("start_clr_pass", m_pass, 0);
          check("start_clr_err", m_err, 0);
          check("start_clr_first", m_first, 'hFFFF);
          if (sb[0].gap) check("idle_gap_cycles", cyc - last_done, 2);
        end
      end
      if (m_busy) begin
        if (m_d != ((blen < int'(NV)) ? vref[blen] : 1'b0)) begin
          sbad++;
          if (sfirst < 0) sfirst = blen;
        end
        blen++;
      end
      if (m_done) begin
        done_cnt++;
        last_done = cyc;
        if (sb.size() == 0 || sb[0].abort) flag("unexpected_done", cyc);
        else begin
          me = sb.pop_front();
          check("pass", m_pass, me.pass);
          check("err_count", m_err, me.err);
          check("first_err_idx", m_first, me.first);
          check("busy_cycles", blen, me.blen);
          check("done_after_busy", bprev, 1);
          check("d_out_stream_errs", sbad, 0);
          if (sbad != 0) $display("  d_out first diverged at run cycle %0d", sfirst);
        end
      end
      bprev = m_busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] l;
    int e, f, ones, dc, bseen;
    n_cmp = 0; n_bad = 0;
    l = SEED;
    for (int i = 0; i < int'(NV); i++) begin
      vref[i] = l[0];
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    reset = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0; mode = 0;
    #12;
    chk_rst("por");

    // Start accepted at the first edge after reset release
    @(negedge clk);
    reset = 1'b1;
    do_run(0, 0, mk(1, 0, 'hFFFF, NV + 1, 0, 0));
    do_run(0, 1, mk(0, 255, 0, NV + 1, 0, 0));
    model(2, 1, 1, e, f);
    do_run(0, 2, mk(0, e, f, NV + 1, 0, 0));
    model(0, 1, 2, e, f);
    do_run(0, 3, mk(0, e, f, NV + 1, 0, 0));
    do_run(1, 0, mk(1, 0, 'hFFFF, NV + 2, 0, 0));

    // start pulses during busy and during DONE are ignored
    sel = 1'b0; mode = 0;
    sb.push_back(mk(1, 0, 'hFFFF, NV + 1, 0, 0));
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (50) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(2000);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    bseen = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_busy) bseen++;
    end
    check("start_in_done_ignored", bseen, 0);

    // Reset during RUN at vector 100
    mode = 2;
    sb.push_back(mk(0, 0, 0, 0, 0, 1));
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (100) @(negedge clk);
    ones = 0;
    for (int i = 0; i < 99; i++) ones += int'(vref[i]);
    check("d_out_vec100", m_d, vref[100]);
    check("err_at_vec100", m_err, ones);
    dc = done_cnt;
    #2 reset = 1'b0;
    #1 chk_rst("abort");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (200) @(negedge clk);
    check("no_done_after_abort", done_cnt - dc, 0);
    do_run(0, 0, mk(1, 0, 'hFFFF, NV + 1, 0, 0));

    // start held high: three back-to-back runs
    sel = 1'b0; mode = 0;
    sb.push_back(mk(1, 0, 'hFFFF, NV + 1, 0, 0));
    sb.push_back(mk(1, 0, 'hFFFF, NV + 1, 1, 0));
    sb.push_back(mk(1, 0, 'hFFFF, NV + 1, 1, 0));
    start_a = 1'b1;
    wait_done(2000);
    wait_done(2000);
    wait_done(2000);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
